parity_check_rx: RTL

// - Receive end of the parity-protected serial link: deserialises DATA_W data bits plus one parity bit per frame,

---
 rtl/parity_link_pkg.sv | 15 +
 rtl/parity_tree.sv | 13 +
 rtl/parity_check_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/parity_link_pkg.sv
// Shared definitions for the parity-protected serial link: default frame geometry,
// parity polarity and the receive FSM state encoding.
package parity_link_pkg;

    localparam int unsigned DataWDefault   = 4;
    localparam bit          ParInvDefault  = 1'b1;
    localparam int unsigned ErrCntWDefault = 8;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity
    } rx_state_e;

endpackage

// File: rtl/parity_tree.sv
// Combinational parity check over a data word plus its parity bit.
// err_o is set when the XOR reduction does not match the link polarity.
module parity_tree #(
    parameter int unsigned W       = 5,
    parameter bit          PAR_INV = 1'b1
) (
    input  logic [W-1:0] bits_i,
    output logic         err_o
);

    assign err_o = (^bits_i) != PAR_INV;

endmodule

// File: rtl/parity_check_rx.sv
// Receive end of the parity-protected serial link: deserialises MSB-first frames,
// checks parity, holds the word on a valid/ready output and counts parity failures.
module parity_check_rx
    import parity_link_pkg::*;
#(
    parameter int unsigned DATA_W    = DataWDefault,
    parameter bit          PAR_INV   = ParInvDefault,
    parameter int unsigned ERR_CNT_W = ErrCntWDefault
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 frame_sync,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_perr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

    rx_state_e             state_q, state_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  commit_q, commit_d;
    logic                  pend_err_q, pend_err_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  out_perr_q, out_perr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  par_err;
    logic                  abort;

    parity_tree #(
        .W       (DATA_W + 1),
        .PAR_INV (PAR_INV)
    ) u_parity_tree (
        .bits_i ({shreg_q, bit_in}),
        .err_o  (par_err)
    );

    // Frame assembly; a parity bit only schedules the commit for the following edge.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        commit_d   = 1'b0;
        pend_err_d = pend_err_q;
        abort      = 1'b0;
        if (bit_valid) begin
            if (frame_sync) begin
                abort   = (state_q != StIdle);
                shreg_d = {{(DATA_W-1){1'b0}}, bit_in};
                cnt_d   = CntW'(1);
                state_d = StData;
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StData: begin
                        shreg_d = {shreg_q[DATA_W-2:0], bit_in};
                        if (cnt_q == CntLast) begin
                            cnt_d   = '0;
                            state_d = StParity;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    StParity: begin
                        commit_d   = 1'b1;
                        pend_err_d = par_err;
                        state_d    = StIdle;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_perr_d  = out_perr_q;
        out_valid_d = out_valid_q;
        err_cnt_d   = err_cnt_q;
        frame_err_d = abort;
        if (commit_q) begin
            out_data_d  = shreg_q;
            out_perr_d  = pend_err_q;
            out_valid_d = 1'b1;
            // Held word not taken: it is overwritten and the loss is flagged.
            if (out_valid_q && !out_ready) begin
                frame_err_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (commit_q && pend_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            commit_q    <= 1'b0;
            pend_err_q  <= 1'b0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            commit_q    <= commit_d;
            pend_err_q  <= pend_err_d;
            out_data_q  <= out_data_d;
            out_perr_q  <= out_perr_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_perr  = out_perr_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign err_count = err_cnt_q;

endmodule
